// File: rtl/booth_divider_8bit.sv
// Sequential signed divider: restoring division on operand magnitudes,
// one quotient bit per clock, followed by a single sign-fix cycle.
module booth_divider_8bit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic             ovf
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a, a_next;
    logic [WIDTH-1:0] q, q_next;
    logic [WIDTH-1:0] m, m_next;
    logic [CW-1:0]    count, count_next;
    logic             sign_q, sign_q_next;
    logic             sign_r, sign_r_next;
    logic             zero, zero_next;
    logic             ovf_pend, ovf_pend_next;
    logic [WIDTH-1:0] quot_next, rem_next;
    logic             busy_next, done_next, dbz_next, ovf_next;

    logic [WIDTH:0]   a_sh, a_sub;
    logic [WIDTH-1:0] q_sh;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            a           <= '0;
            q           <= '0;
            m           <= '0;
            count       <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            zero        <= 1'b0;
            ovf_pend    <= 1'b0;
            quot        <= '0;
            rem         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            ovf         <= 1'b0;
        end else begin
            state       <= state_next;
            a           <= a_next;
            q           <= q_next;
            m           <= m_next;
            count       <= count_next;
            sign_q      <= sign_q_next;
            sign_r      <= sign_r_next;
            zero        <= zero_next;
            ovf_pend    <= ovf_pend_next;
            quot        <= quot_next;
            rem         <= rem_next;
            busy        <= busy_next;
            done        <= done_next;
            div_by_zero <= dbz_next;
            ovf         <= ovf_next;
        end
    end

    // Next-state and datapath logic; a load restarts from any state
    always_comb begin
        state_next    = state;
        a_next        = a;
        q_next        = q;
        m_next        = m;
        count_next    = count;
        sign_q_next   = sign_q;
        sign_r_next   = sign_r;
        zero_next     = zero;
        ovf_pend_next = ovf_pend;
        quot_next     = quot;
        rem_next      = rem;
        busy_next     = busy;
        done_next     = done;
        dbz_next      = div_by_zero;
        ovf_next      = ovf;

        a_sh  = {a, q[WIDTH-1]};
        q_sh  = {q[WIDTH-2:0], 1'b0};
        a_sub = a_sh - {1'b0, m};

        case (state)
            CALC: begin
                if (!a_sub[WIDTH]) begin
                    a_next = a_sub[WIDTH-1:0];
                    q_next = q_sh | WIDTH'(1);
                end else begin
                    a_next = a_sh[WIDTH-1:0];
                    q_next = q_sh;
                end
                count_next = count + CW'(1);
                if (count == CW'(WIDTH - 1)) state_next = FIX;
            end
            FIX: begin
                if (zero) begin
                    quot_next = '1;
                    rem_next  = sign_r ? -q : q;
                end else begin
                    quot_next = sign_q ? -q : q;
                    rem_next  = sign_r ? -a : a;
                end
                busy_next  = 1'b0;
                done_next  = 1'b1;
                dbz_next   = zero;
                ovf_next   = ovf_pend;
                state_next = IDLE;
            end
            default: ;
        endcase

        if (load) begin
            sign_q_next   = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            sign_r_next   = dividend[WIDTH-1];
            q_next        = dividend[WIDTH-1] ? -dividend : dividend;
            m_next        = divisor[WIDTH-1] ? -divisor : divisor;
            a_next        = '0;
            count_next    = '0;
            zero_next     = (divisor == '0);
            // Only most-negative / -1 overflows the quotient range
            ovf_pend_next = (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);
            busy_next     = 1'b1;
            done_next     = 1'b0;
            dbz_next      = 1'b0;
            ovf_next      = 1'b0;
            state_next    = (divisor == '0) ? FIX : CALC;
        end
    end

endmodule

// File: tb/tb_booth_divider_8bit.sv
// Self-checking bench for booth_divider_8bit: directed vector table,
// multi-cycle corner sequences and randomized operands against an arithmetic model.
module tb_booth_divider_8bit;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [7:0] dividend, divisor;
    logic [7:0] quot, rem;
    logic       busy, done, div_by_zero, ovf;

    int total = 0;
    int bad   = 0;
    logic [7:0] prev_q;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
        logic       ov;
        int         lat;
    } vec_t;

    vec_t vecs[8];

    booth_divider_8bit #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .load(load),
        .dividend(dividend), .divisor(divisor),
        .quot(quot), .rem(rem), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Plain signed arithmetic: truncating quotient, remainder follows dividend
    function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] q, output logic [7:0] r,
                                  output logic dbz, output logic ov);
        int sa, sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        dbz = 1'b0;
        ov  = 1'b0;
        if (sb == 0) begin
            q = 8'hFF; r = a; dbz = 1'b1;
        end else if (sa == -128 && sb == -1) begin
            q = 8'h80; r = 8'h00; ov = 1'b1;
        end else begin
            q = 8'(sa / sb);
            r = 8'(sa % sb);
        end
    endfunction

    task automatic pulse_load(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        load     = 1'b1;
        @(posedge clk);
        #1;
        load     = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    task automatic run_div(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] eq, input logic [7:0] er,
                           input logic edbz, input logic eov, input int elat);
        int edges;
        pulse_load(a, b);
        check({tag, ".busy_start"}, 32'(busy), 32'd1);
        check({tag, ".done_start"}, 32'(done), 32'd0);
        check({tag, ".stale_quot"}, 32'(quot), 32'(prev_q));
        edges = 0;
        while (!done && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check({tag, ".latency"}, 32'(edges), 32'(elat));
        check({tag, ".quot"}, 32'(quot), 32'(eq));
        check({tag, ".rem"}, 32'(rem), 32'(er));
        check({tag, ".busy"}, 32'(busy), 32'd0);
        check({tag, ".dbz"}, 32'(div_by_zero), 32'(edbz));
        check({tag, ".ovf"}, 32'(ovf), 32'(eov));
        prev_q = eq;
    endtask

    initial begin
        vecs[0] = '{8'd82,    8'd29,    8'd2,    8'd24,     1'b0, 1'b0, 9};
        vecs[1] = '{8'd113,   8'(-78),  8'hFF,   8'd35,     1'b0, 1'b0, 9};
        vecs[2] = '{8'(-48),  8'd10,    8'hFC,   8'hF8,     1'b0, 1'b0, 9};
        vecs[3] = '{8'(-105), 8'(-126), 8'd0,    8'(-105),  1'b0, 1'b0, 9};
        vecs[4] = '{8'd37,    8'd0,     8'hFF,   8'd37,     1'b1, 1'b0, 1};
        vecs[5] = '{8'h80,    8'hFF,    8'h80,   8'd0,      1'b0, 1'b1, 9};
        vecs[6] = '{8'h80,    8'd1,     8'h80,   8'd0,      1'b0, 1'b0, 9};
        vecs[7] = '{8'd100,   8'd7,     8'd14,   8'd2,      1'b0, 1'b0, 9};

        rst = 1'b1; load = 1'b0; dividend = '0; divisor = '0;
        prev_q = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("reset.quot", 32'(quot), 32'd0);
        check("reset.rem", 32'(rem), 32'd0);
        check("reset.flags", 32'({busy, done, div_by_zero, ovf}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++)
            run_div($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q,
                    vecs[i].r, vecs[i].dbz, vecs[i].ov, vecs[i].lat);

        // Asynchronous reset in the middle of a division
        pulse_load(8'd100, 8'd7);
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("midrst.quot", 32'(quot), 32'd0);
        check("midrst.rem", 32'(rem), 32'd0);
        check("midrst.flags", 32'({busy, done, div_by_zero, ovf}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        prev_q = 8'h00;
        run_div("after_rst", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b0, 9);

        // Reload while busy: only the second operands count
        begin
            int early_done;
            early_done = 0;
            pulse_load(8'd50, 8'd3);
            repeat (2) begin
                @(posedge clk);
                #1;
                if (done) early_done++;
            end
            pulse_load(8'd120, 8'd11);
            repeat (8) begin
                @(posedge clk);
                #1;
                if (done) early_done++;
            end
            check("reload.no_early_done", 32'(early_done), 32'd0);
            @(posedge clk);
            #1;
            check("reload.done", 32'(done), 32'd1);
            check("reload.quot", 32'(quot), 32'd10);
            check("reload.rem", 32'(rem), 32'd10);
            prev_q = 8'd10;
        end

        // Randomized operands against the arithmetic model
        for (int i = 0; i < 150; i++) begin
            logic [7:0] a, b, eq, er;
            logic edbz, eov;
            a = 8'($urandom);
            b = 8'($urandom);
            if (i % 25 == 3) b = 8'h00;
            if (i % 25 == 7) begin a = 8'h80; b = 8'hFF; end
            if (i % 25 == 11) b = 8'hFF;
            model(a, b, eq, er, edbz, eov);
            run_div($sformatf("rnd%0d", i), a, b, eq, er, edbz, eov, edbz ? 1 : 9);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/booth_divider_8bit.md
Name: booth_divider_8bit

Overview:
- Sequential signed binary divider; the inverse operation of the team's sequential Booth multiplier, sharing its operand-load/clock/reset style.
- Computes truncating signed quotient and remainder of two WIDTH-bit two's-complement operands.
- Iterates one restoring step per clock on operand magnitudes, then applies a sign-fix cycle.
- Feeds the ALU datapath in the same lab processor as the multiplier.

Parameters:
WIDTH, 8, operand/result width in bits (two's complement)

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous, active-high reset
load  input  1  start strobe; operands sampled on the rising clk edge where load=1
dividend  input  WIDTH  signed dividend
divisor  input  WIDTH  signed divisor
quot  output  WIDTH  signed quotient, registered
rem  output  WIDTH  signed remainder, registered
busy  output  1  high while a division is in progress
done  output  1  high when quot/rem are valid; held until next load or rst
div_by_zero  output  1  set with done when the captured divisor was 0
ovf  output  1  set with done for the (-2^(WIDTH-1)) / (-1) case

Behaviour:
- Reset: rst=1 forces, immediately (asynchronous), state=IDLE; quot=0, rem=0, busy=0, done=0, div_by_zero=0, ovf=0; all internal registers cleared. Reset mid-operation aborts with no partial result.
- States: IDLE, CALC, FIX.
- IDLE: on edge E0 with load=1:
  - capture sign_q = dividend[MSB]^divisor[MSB] and sign_r = dividend[MSB];
  - capture magnitudes |dividend| and |divisor| as WIDTH-bit unsigned (|-128| = 8'h80);
  - clear done/div_by_zero/ovf; set busy=1; count=0; A (WIDTH+1 bits)=0; Q=|dividend|.
  - If divisor==0, go to FIX with the zero flag set; otherwise go to CALC.
- CALC, one step per edge E1..E_WIDTH:
  - shift {A,Q} left by 1;
  - compute A' = A - |divisor|;
  - if A' is non-negative: A=A', Q[0]=1; else keep A, Q[0]=0;
  - increment count; after step WIDTH go to FIX.
- FIX, edge E_(WIDTH+1):
  - quot = sign_q ? -Q : Q; rem = sign_r ? -A[WIDTH-1:0] : A[WIDTH-1:0];
  - busy=0, done=1, return to IDLE.
- Divide-by-zero: FIX at edge E1 gives quot = all ones (-1), rem = dividend, div_by_zero=1, done=1. CALC is skipped, so latency is 1.
- Overflow: dividend = 100..0 with divisor = -1 gives quot = 100..0 (wrapped), rem=0, ovf=1. Other ovf cases cannot occur.
- Latency: normal case, done rises WIDTH+1 edges after the load edge (9 for WIDTH=8).
- Result semantics: quotient truncates toward zero; remainder takes the dividend's sign; dividend = quot*divisor + rem always holds.
- Outputs quot/rem/flags change only in FIX and are otherwise held stable. Stale results remain visible while busy, but done=0 during that time.
- load while busy: restarts with the new operands on that edge; the in-flight result is discarded and the latency counts from the new load edge.
- load held high for multiple cycles: each edge with load=1 restarts; the result appears WIDTH+1 edges after the last such edge.
- load and rst together: rst dominates.
- Operand inputs are ignored on edges without load; they may change freely after the load edge.

Test Plan:
- rst pulse, then load 82 / 29 -> after 9 edges done=1, quot=2, rem=24, busy=0, flags 0; outputs read 0 during reset.
- load 113 / -78 -> quot=-1 (8'hFF), rem=35; then load -48 / 10 -> quot=-4 (8'hFC), rem=-8 (8'hF8); then load -105 / -126 -> quot=0, rem=-105.
- load 37 / 0 -> one edge later done=1, div_by_zero=1, quot=8'hFF, rem=37, ovf=0.
- load -128 / -1 -> quot=8'h80, rem=0, ovf=1; load -128 / 1 -> quot=-128, rem=0, ovf=0.
- load 100 / 7, assert rst at edge 4 -> all outputs 0 immediately; then load 100 / 7 -> quot=14, rem=2 at 9 edges after the load.
- load 50 / 3, re-load 120 / 11 at edge 3 -> no done before edge 12; then quot=10, rem=10 exactly 9 edges after the second load.
